seg7_scan_ctrl: RTL and testbench

- Time-multiplexed scan controller for a common-anode multi-digit 7-segment display.
- Owns one shared bcd_to_7seg decoder instance and steps it through DIGITS BCD nibbles, one digit slot at a time.
- Each slot has a blanking guard against ghosting.
- New display values are accepted by a load strobe and applied only at frame boundaries, so a frame never shows torn values.

---
 rtl/seg7_scan_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: time-multiplexed scan controller for a common-anode
// multi-digit 7-segment display with frame-synchronous value updates.
//
// Parameters:
//   DIGITS       digits scanned (2..8)
//   CLK_DIV      clock cycles per digit slot (>= 4)
//   BLANK_CYCLES all-anodes-off guard at each slot start (1..CLK_DIV-2)
//
// Ports:
//   clk        system clock
//   rst        synchronous, active-high reset
//   load       one-cycle strobe capturing value_in / dp_in
//   value_in   BCD nibbles, digit k = value_in[4k+3:4k], digit 0 rightmost
//   dp_in      decimal point per digit, 1 = lit
//   busy       a loaded value is pending and not yet displayed
//   frame_done one-cycle pulse following the last slot of each scan
//   an         anode enables, active-low, at most one low
//   seg        segments a..g = seg[0]..seg[6], active-high
//   dp         decimal point of the active digit, active-high
//
// Optional build macro:
//   LEADING_ZERO_BLANK_EN  suppress segments of digits above the most
//                          significant nonzero nibble (digit 0 always shown)

module bcd_to_7seg (
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  // Segment order g f e d c b a; nibbles 10..15 stay dark.
  always_comb begin
    seg_o = 7'b0000000;
    unique case (bcd_i)
      4'd0:    seg_o = 7'b0111111;
      4'd1:    seg_o = 7'b0000110;
      4'd2:    seg_o = 7'b1011011;
      4'd3:    seg_o = 7'b1001111;
      4'd4:    seg_o = 7'b1100110;
      4'd5:    seg_o = 7'b1101101;
      4'd6:    seg_o = 7'b1111101;
      4'd7:    seg_o = 7'b0000111;
      4'd8:    seg_o = 7'b1111111;
      4'd9:    seg_o = 7'b1101111;
      default: seg_o = 7'b0000000;
    endcase
  end

endmodule

module seg7_scan_ctrl #(
  parameter int DIGITS       = 4,
  parameter int CLK_DIV      = 50000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value_in,
  input  logic [DIGITS-1:0]     dp_in,
  output logic                  busy,
  output logic                  frame_done,
  output logic [DIGITS-1:0]     an,
  output logic [6:0]            seg,
  output logic                  dp
);

  localparam int CW = $clog2(CLK_DIV);
  localparam int IW = $clog2(DIGITS);

  localparam logic [CW-1:0] CNT_LAST   = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);

  localparam logic [0:0] BLANK = 1'b0;
  localparam logic [0:0] SHOW  = 1'b1;

  logic [CW-1:0]       cnt_q, cnt_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [0:0]          state_q, state_d;
  logic [4*DIGITS-1:0] disp_q, disp_d;
  logic [DIGITS-1:0]   disp_dp_q, disp_dp_d;
  logic [4*DIGITS-1:0] pend_q, pend_d;
  logic [DIGITS-1:0]   pend_dp_q, pend_dp_d;
  logic                busy_q, busy_d;
  logic                frame_q, frame_d;
  logic [DIGITS-1:0]   an_q, an_d;
  logic [6:0]          seg_q, seg_d;
  logic                dp_q, dp_d;

  logic                slot_end;
  logic                boundary;
  logic [3:0]          nib;
  logic [6:0]          dec_seg;
  logic                lz_blank;

  bcd_to_7seg u_dec (
    .bcd_i (nib),
    .seg_o (dec_seg)
  );

  // Scan position and FSM.
  always_comb begin
    slot_end = (cnt_q == CNT_LAST);
    boundary = slot_end && (idx_q == IDX_LAST);
    cnt_d    = slot_end ? '0 : cnt_q + 1'b1;
    idx_d    = idx_q;
    if (slot_end) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end
    state_d = state_q;
    if (cnt_q == BLANK_LAST) begin
      state_d = SHOW;
    end else if (slot_end) begin
      state_d = BLANK;
    end
  end

  // Pending/display registers: a load in the boundary cycle becomes
  // the new pending value while the old one is committed to disp.
  always_comb begin
    pend_d    = pend_q;
    pend_dp_d = pend_dp_q;
    disp_d    = disp_q;
    disp_dp_d = disp_dp_q;
    busy_d    = busy_q | load;
    frame_d   = boundary;
    if (load) begin
      pend_d    = value_in;
      pend_dp_d = dp_in;
    end
    if (boundary) begin
      if (busy_q) begin
        disp_d    = pend_q;
        disp_dp_d = pend_dp_q;
      end
      busy_d = load;
    end
  end

  // Outputs are computed from next-state so they line up with cnt.
  assign nib = disp_d[{idx_d, 2'b00} +: 4];

`ifdef LEADING_ZERO_BLANK_EN
  logic [IW-1:0] msnz;

  always_comb begin
    msnz = '0;
    for (int k = 0; k < DIGITS; k++) begin
      if (disp_d[4*k +: 4] != 4'd0) begin
        msnz = IW'(k);
      end
    end
    lz_blank = (idx_d > msnz);
  end
`else
  assign lz_blank = 1'b0;
`endif

  always_comb begin
    an_d  = '1;
    seg_d = '0;
    dp_d  = 1'b0;
    if (state_d == SHOW) begin
      an_d  = ~(DIGITS'(1) << idx_d);
      seg_d = lz_blank ? 7'b0000000 : dec_seg;
      dp_d  = disp_dp_d[idx_d];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      idx_q     <= '0;
      state_q   <= BLANK;
      disp_q    <= '0;
      disp_dp_q <= '0;
      pend_q    <= '0;
      pend_dp_q <= '0;
      busy_q    <= 1'b0;
      frame_q   <= 1'b0;
      an_q      <= '1;
      seg_q     <= '0;
      dp_q      <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      state_q   <= state_d;
      disp_q    <= disp_d;
      disp_dp_q <= disp_dp_d;
      pend_q    <= pend_d;
      pend_dp_q <= pend_dp_d;
      busy_q    <= busy_d;
      frame_q   <= frame_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
      dp_q      <= dp_d;
    end
  end

  assign busy       = busy_q;
  assign frame_done = frame_q;
  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb_seg7_scan_ctrl: directed bench for seg7_scan_ctrl
// (DIGITS=4, CLK_DIV=8, BLANK_CYCLES=2; one frame = 32 cycles).
module tb_seg7_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [15:0] value_in = '0;
  logic [3:0]  dp_in = '0;
  logic        busy;
  logic        frame_done;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  int errors = 0;
  int checks = 0;
  int cyc_abs = 0;
  int base = 0;

  localparam logic [6:0] S0 = 7'b0111111;
  localparam logic [6:0] S1 = 7'b0000110;
  localparam logic [6:0] S2 = 7'b1011011;
  localparam logic [6:0] S3 = 7'b1001111;
  localparam logic [6:0] S4 = 7'b1100110;
  localparam logic [6:0] S5 = 7'b1101101;
  localparam logic [6:0] S9 = 7'b1101111;

  seg7_scan_ctrl #(
    .DIGITS(4),
    .CLK_DIV(8),
    .BLANK_CYCLES(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .load(load),
    .value_in(value_in),
    .dp_in(dp_in),
    .busy(busy),
    .frame_done(frame_done),
    .an(an),
    .seg(seg),
    .dp(dp)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_abs <= cyc_abs + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // Returns at the falling edge inside cycle n (cycle 0 = before edge 0).
  task automatic wait_cyc(input int n);
    while (cyc_abs - base < n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    load = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    base = cyc_abs;
  endtask

  task automatic pulse_load(input int c, input logic [15:0] v,
                            input logic [3:0] d);
    wait_cyc(c);
    load = 1'b1;
    value_in = v;
    dp_in = d;
    wait_cyc(c + 1);
    load = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    wait_cyc(0);
    checks++;
    if ({an, seg, dp, busy, frame_done} !== {4'b1111, 7'd0, 3'b000}) begin
      errors++;
      $display("FAIL reset_c0: got an=%b seg=%b dp=%b busy=%b fd=%b expected 1111 0000000 0 0 0",
               an, seg, dp, busy, frame_done);
    end
    wait_cyc(1);
    checks++;
    if (an !== 4'b1111 || seg !== 7'd0) begin
      errors++;
      $display("FAIL reset_c1: got an=%b seg=%b expected 1111 0000000", an, seg);
    end
    wait_cyc(2);
    checks++;
    if (an !== 4'b1110 || seg !== S0) begin
      errors++;
      $display("FAIL slot0_c2: got an=%b seg=%b expected 1110 %b", an, seg, S0);
    end
    wait_cyc(7);
    checks++;
    if (an !== 4'b1110 || seg !== S0) begin
      errors++;
      $display("FAIL slot0_c7: got an=%b seg=%b expected 1110 %b", an, seg, S0);
    end
    wait_cyc(8);
    checks++;
    if (an !== 4'b1111 || seg !== 7'd0) begin
      errors++;
      $display("FAIL guard_c8: got an=%b seg=%b expected 1111 0000000", an, seg);
    end
    wait_cyc(10);
    checks++;
    if (an !== 4'b1101 || seg !== S0) begin
      errors++;
      $display("FAIL slot1_c10: got an=%b seg=%b expected 1101 %b", an, seg, S0);
    end
    wait_cyc(15);
    checks++;
    if (an !== 4'b1101) begin
      errors++;
      $display("FAIL slot1_c15: got an=%b expected 1101", an);
    end
  endtask

  task automatic test_load();
    logic [6:0] es [4] = '{S4, S3, S2, S1};
    logic [3:0] ed = 4'b0100;
    logic [3:0] ea;
    do_reset();
    pulse_load(3, 16'h1234, 4'b0100);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL load_busy_c4: got %b expected 1", busy);
    end
    wait_cyc(20);
    checks++;
    if (an !== 4'b1011 || seg !== S0 || dp !== 1'b0) begin
      errors++;
      $display("FAIL load_old_c20: got an=%b seg=%b dp=%b expected 1011 %b 0",
               an, seg, dp, S0);
    end
    wait_cyc(31);
    checks++;
    if (busy !== 1'b1 || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL load_c31: got busy=%b fd=%b expected 1 0", busy, frame_done);
    end
    wait_cyc(32);
    checks++;
    if (busy !== 1'b0 || frame_done !== 1'b1) begin
      errors++;
      $display("FAIL load_c32: got busy=%b fd=%b expected 0 1", busy, frame_done);
    end
    wait_cyc(33);
    checks++;
    if (frame_done !== 1'b0) begin
      errors++;
      $display("FAIL load_fd_c33: got %b expected 0", frame_done);
    end
    for (int k = 0; k < 4; k++) begin
      wait_cyc(36 + 8 * k);
      ea = ~(4'b0001 << k);
      checks++;
      if (an !== ea || seg !== es[k] || dp !== ed[k]) begin
        errors++;
        $display("FAIL load_digit%0d: got an=%b seg=%b dp=%b expected %b %b %b",
                 k, an, seg, dp, ea, es[k], ed[k]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int drops = 0;
    do_reset();
    for (int c = 5; c <= 31; c++) begin
      wait_cyc(c);
      if (c >= 6 && busy !== 1'b1) drops++;
      load = (c == 5) || (c == 9);
      value_in = (c == 5) ? 16'h1111 : 16'h9999;
      dp_in = 4'b0000;
    end
    wait_cyc(32);
    load = 1'b0;
    checks++;
    if (drops != 0) begin
      errors++;
      $display("FAIL b2b_busy_hold: got %0d low samples expected 0", drops);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_busy_c32: got %b expected 0", busy);
    end
    for (int k = 0; k < 4; k++) begin
      wait_cyc(37 + 8 * k);
      checks++;
      if (seg !== S9) begin
        errors++;
        $display("FAIL b2b_digit%0d: got seg=%b expected %b", k, seg, S9);
      end
    end
  endtask

  task automatic test_boundary_load();
    do_reset();
    pulse_load(3, 16'h1234, 4'b0000);
    pulse_load(31, 16'h5555, 4'b0000);
    checks++;
    if (busy !== 1'b1 || frame_done !== 1'b1) begin
      errors++;
      $display("FAIL bnd_c32: got busy=%b fd=%b expected 1 1", busy, frame_done);
    end
    wait_cyc(36);
    checks++;
    if (an !== 4'b1110 || seg !== S4) begin
      errors++;
      $display("FAIL bnd_f1_d0: got an=%b seg=%b expected 1110 %b", an, seg, S4);
    end
    wait_cyc(60);
    checks++;
    if (an !== 4'b0111 || seg !== S1) begin
      errors++;
      $display("FAIL bnd_f1_d3: got an=%b seg=%b expected 0111 %b", an, seg, S1);
    end
    wait_cyc(63);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL bnd_busy_c63: got %b expected 1", busy);
    end
    wait_cyc(64);
    checks++;
    if (busy !== 1'b0 || frame_done !== 1'b1) begin
      errors++;
      $display("FAIL bnd_c64: got busy=%b fd=%b expected 0 1", busy, frame_done);
    end
    wait_cyc(68);
    checks++;
    if (seg !== S5) begin
      errors++;
      $display("FAIL bnd_f2_d0: got seg=%b expected %b", seg, S5);
    end
    wait_cyc(92);
    checks++;
    if (an !== 4'b0111 || seg !== S5) begin
      errors++;
      $display("FAIL bnd_f2_d3: got an=%b seg=%b expected 0111 %b", an, seg, S5);
    end
  endtask

  task automatic test_invalid_bcd();
    logic [6:0] es [4] = '{S3, 7'd0, S0, 7'd0};
    logic [3:0] ea;
    do_reset();
    pulse_load(3, 16'hA0F3, 4'b1010);
    for (int k = 0; k < 4; k++) begin
      wait_cyc(36 + 8 * k);
      ea = ~(4'b0001 << k);
      checks++;
      if (an !== ea || seg !== es[k] || dp !== ea[k] ^ 1'b1 ^ (k % 2 == 0)) begin
        errors++;
        $display("FAIL inv_digit%0d: got an=%b seg=%b dp=%b expected %b %b %b",
                 k, an, seg, dp, ea, es[k], (k % 2 == 1));
      end
    end
  endtask

  task automatic test_leading_zero();
`ifdef LEADING_ZERO_BLANK_EN
    logic [6:0] es [4] = '{S2, S4, 7'd0, 7'd0};
`else
    logic [6:0] es [4] = '{S2, S4, S0, S0};
`endif
    logic [3:0] ed = 4'b1000;
    logic [3:0] ea;
    do_reset();
    pulse_load(3, 16'h0042, 4'b1000);
    for (int k = 0; k < 4; k++) begin
      wait_cyc(36 + 8 * k);
      ea = ~(4'b0001 << k);
      checks++;
      if (an !== ea || seg !== es[k] || dp !== ed[k]) begin
        errors++;
        $display("FAIL lz_digit%0d: got an=%b seg=%b dp=%b expected %b %b %b",
                 k, an, seg, dp, ea, es[k], ed[k]);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    pulse_load(3, 16'h1234, 4'b1111);
    wait_cyc(13);
    rst = 1'b1;
    wait_cyc(14);
    checks++;
    if (an !== 4'b1111 || busy !== 1'b0 || seg !== 7'd0 || dp !== 1'b0) begin
      errors++;
      $display("FAIL midrst_c14: got an=%b busy=%b seg=%b dp=%b expected 1111 0 0000000 0",
               an, busy, seg, dp);
    end
    do_reset();
    wait_cyc(4);
    checks++;
    if (an !== 4'b1110 || seg !== S0 || dp !== 1'b0) begin
      errors++;
      $display("FAIL midrst_d0: got an=%b seg=%b dp=%b expected 1110 %b 0",
               an, seg, dp, S0);
    end
    wait_cyc(36);
    checks++;
    if (seg !== S0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midrst_discard: got seg=%b busy=%b expected %b 0", seg, busy, S0);
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_back_to_back();
    test_boundary_load();
    test_invalid_bcd();
    test_leading_zero();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
